debug_ring_node: RTL and testbench

//  Parametrised two-lane ring stop for the debug interconnect. Generalises the fixed 16-bit ring router:

---
 rtl/debug_ring_node_if.sv | 14 +
 rtl/debug_ring_node.sv | 180 ++++++++++++++++++
 tb/tb_debug_ring_node.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_ring_node_if.sv
// Flit stream bundle shared by every ring and local port of debug_ring_node.
// The master drives the flit fields and valid; the slave returns ready.
interface debug_ring_node_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  first;
  logic                  last;
  logic                  ready;

  modport master (output data, valid, first, last, input ready);
  modport slave  (input data, valid, first, last, output ready);
endinterface

// File: rtl/debug_ring_node.sv
// Two-lane debug ring stop: per-lane input FIFOs, packet routing by destination id,
// packet-atomic round-robin arbitration onto ring_out0 and local_out, terminal drop counting.
module debug_ring_node #(
  parameter int DATA_WIDTH  = 16,
  parameter int ID_WIDTH    = 10,
  parameter int BUFFER_SIZE = 4,
  parameter bit TERMINAL    = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_WIDTH-1:0] id,
  debug_ring_node_if.slave    ring_in0,
  debug_ring_node_if.slave    ring_in1,
  debug_ring_node_if.master   ring_out0,
  debug_ring_node_if.master   ring_out1,
  debug_ring_node_if.slave    local_in,
  debug_ring_node_if.master   local_out,
  output logic [15:0]         drop_count
);
  localparam int          AW    = $clog2(BUFFER_SIZE);
  localparam logic [AW:0] DEPTH = (AW+1)'(BUFFER_SIZE);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_LOCAL = 2'd1;
  localparam logic [1:0] R_FWD   = 2'd2;
  localparam logic [1:0] R_DROP  = 2'd3;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_A    = 2'd1;
  localparam logic [1:0] G_B    = 2'd2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  first;
    logic                  last;
  } flit_t;

  flit_t         mem [2][BUFFER_SIZE];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [AW:0]   count [2];
  logic [1:0]    route_q [2];

  flit_t      in_flit [2];
  flit_t      head [2];
  logic [1:0] route_eff [2];
  logic [1:0] in_valid, in_ready, push, pop, head_valid;
  logic [1:0] fwd_req, loc_req, drop_pop;

  logic [1:0]  o0_grant_q, lo_grant_q, o0_gnt, lo_gnt;
  logic        o0_rr_q, lo_rr_q;
  flit_t       lin_flit, o0_flit, lo_flit;
  logic        o0_valid, lo_valid, o0_hs, lo_hs;
  logic [15:0] drop_count_q;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign in_flit[0] = '{data: ring_in0.data, first: ring_in0.first, last: ring_in0.last};
  assign in_flit[1] = '{data: ring_in1.data, first: ring_in1.first, last: ring_in1.last};
  assign lin_flit   = '{data: local_in.data, first: local_in.first, last: local_in.last};
  assign in_valid   = {ring_in1.valid, ring_in0.valid};
  assign ring_in0.ready = in_ready[0];
  assign ring_in1.ready = in_ready[1];

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      head[l]       = mem[l][rd_ptr[l]];
      head_valid[l] = (count[l] != '0);
      in_ready[l]   = (count[l] < DEPTH);
      push[l]       = in_valid[l] && in_ready[l];
      route_eff[l]  = route_q[l];
      // An idle lane routes from its head flit; a non-first head here is debris to resync past.
      if (route_q[l] == R_IDLE && head_valid[l]) begin
        if (!head[l].first)                            route_eff[l] = R_DROP;
        else if (head[l].data[ID_WIDTH-1:0] == id)     route_eff[l] = R_LOCAL;
        else if (l == 1 && TERMINAL)                   route_eff[l] = R_DROP;
        else                                           route_eff[l] = R_FWD;
      end
      fwd_req[l]  = head_valid[l] && (route_eff[l] == R_FWD);
      loc_req[l]  = head_valid[l] && (route_eff[l] == R_LOCAL);
      drop_pop[l] = head_valid[l] && (route_eff[l] == R_DROP);
    end
  end

  // A held grant wins outright; an idle arbiter only starts packets on a first flit.
  function automatic logic [1:0] arb_pick(input logic [1:0] grant, input logic rr_b,
                                          input logic a_ok, input logic b_ok);
    logic [1:0] pick;
    pick = grant;
    if (grant == G_NONE) begin
      if (a_ok && b_ok) pick = rr_b ? G_B : G_A;
      else if (a_ok)    pick = G_A;
      else if (b_ok)    pick = G_B;
    end
    return pick;
  endfunction

  assign o0_gnt = arb_pick(o0_grant_q, o0_rr_q, fwd_req[0] && head[0].first,
                           local_in.valid && local_in.first);
  assign lo_gnt = arb_pick(lo_grant_q, lo_rr_q, loc_req[0] && head[0].first,
                           loc_req[1] && head[1].first);

  assign o0_valid = (o0_gnt == G_A && fwd_req[0]) || (o0_gnt == G_B && local_in.valid);
  assign o0_flit  = (o0_gnt == G_B) ? lin_flit : head[0];
  assign o0_hs    = o0_valid && ring_out0.ready;
  assign lo_valid = (lo_gnt == G_A && loc_req[0]) || (lo_gnt == G_B && loc_req[1]);
  assign lo_flit  = (lo_gnt == G_B) ? head[1] : head[0];
  assign lo_hs    = lo_valid && local_out.ready;

  assign ring_out0.valid = o0_valid;
  assign ring_out0.data  = o0_flit.data;
  assign ring_out0.first = o0_flit.first;
  assign ring_out0.last  = o0_flit.last;
  assign local_in.ready  = (o0_gnt == G_B) && ring_out0.ready;

  assign ring_out1.valid = fwd_req[1];
  assign ring_out1.data  = head[1].data;
  assign ring_out1.first = head[1].first;
  assign ring_out1.last  = head[1].last;

  assign local_out.valid = lo_valid;
  assign local_out.data  = lo_flit.data;
  assign local_out.first = lo_flit.first;
  assign local_out.last  = lo_flit.last;

  assign pop = {
    (fwd_req[1] && ring_out1.ready) || (lo_gnt == G_B && loc_req[1] && local_out.ready) || drop_pop[1],
    (o0_gnt == G_A && fwd_req[0] && ring_out0.ready) ||
      (lo_gnt == G_A && loc_req[0] && local_out.ready) || drop_pop[0]
  };

  assign drop_inc   = {1'b0, drop_pop[0] && head[0].last} + {1'b0, drop_pop[1] && head[1].last};
  assign drop_sum   = {1'b0, drop_count_q} + {15'd0, drop_inc};
  assign drop_count = drop_count_q;

  // NOTE: the flit storage has no reset; the pointers and counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (push[l]) mem[l][wr_ptr[l]] <= in_flit[l];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        wr_ptr[l]  <= '0;
        rd_ptr[l]  <= '0;
        count[l]   <= '0;
        route_q[l] <= R_IDLE;
      end
      o0_grant_q   <= G_NONE;
      o0_rr_q      <= 1'b0;
      lo_grant_q   <= G_NONE;
      lo_rr_q      <= 1'b0;
      drop_count_q <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (push[l]) wr_ptr[l] <= wr_ptr[l] + 1'b1;
        if (pop[l]) begin
          rd_ptr[l]  <= rd_ptr[l] + 1'b1;
          route_q[l] <= head[l].last ? R_IDLE : route_eff[l];
        end
        if (push[l] && !pop[l])      count[l] <= count[l] + 1'b1;
        else if (!push[l] && pop[l]) count[l] <= count[l] - 1'b1;
      end
      // The pointer moves to the source that did not just finish a packet.
      if (o0_hs) begin
        o0_grant_q <= o0_flit.last ? G_NONE : o0_gnt;
        if (o0_flit.last) o0_rr_q <= (o0_gnt == G_A);
      end
      if (lo_hs) begin
        lo_grant_q <= lo_flit.last ? G_NONE : lo_gnt;
        if (lo_flit.last) lo_rr_q <= (lo_gnt == G_A);
      end
      if (TERMINAL) drop_count_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
endmodule

// File: tb/tb_debug_ring_node.sv
// Directed bench for debug_ring_node: a TERMINAL=0 node (id 3) and a TERMINAL=1 node (id 7).
module tb_debug_ring_node;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] id0, id1;
  logic [15:0] drop0, drop1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_ring_node_if #(16) a_in0 (), a_in1 (), a_out0 (), a_out1 (), a_lin (), a_lout ();
  debug_ring_node_if #(16) b_in0 (), b_in1 (), b_out0 (), b_out1 (), b_lin (), b_lout ();

  debug_ring_node #(.DATA_WIDTH(16), .ID_WIDTH(10), .BUFFER_SIZE(4), .TERMINAL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .id(id0),
    .ring_in0(a_in0), .ring_in1(a_in1), .ring_out0(a_out0), .ring_out1(a_out1),
    .local_in(a_lin), .local_out(a_lout), .drop_count(drop0)
  );

  debug_ring_node #(.DATA_WIDTH(16), .ID_WIDTH(10), .BUFFER_SIZE(4), .TERMINAL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id(id1),
    .ring_in0(b_in0), .ring_in1(b_in1), .ring_out0(b_out0), .ring_out1(b_out1),
    .local_in(b_lin), .local_out(b_lout), .drop_count(drop1)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        f;
    logic        l;
    logic        ro0_rdy;
    logic        exp_in_rdy;
    logic        exp_ro0_v;
    logic [15:0] exp_ro0_d;
    logic        exp_lo_v;
    logic [15:0] exp_lo_d;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "_ro0_valid"}, a_out0.valid, 0);
    check({tag, "_ro1_valid"}, a_out1.valid, 0);
    check({tag, "_lo_valid"},  a_lout.valid, 0);
    check({tag, "_in0_ready"}, a_in0.ready, 1);
    check({tag, "_in1_ready"}, a_in1.ready, 1);
    check({tag, "_lin_ready"}, a_lin.ready, 0);
    check({tag, "_drop1"},     drop1, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    a_in0.valid = 0; a_in0.data = '0; a_in0.first = 0; a_in0.last = 0;
    a_in1.valid = 0; a_in1.data = '0; a_in1.first = 0; a_in1.last = 0;
    a_lin.valid = 0; a_lin.data = '0; a_lin.first = 0; a_lin.last = 0;
    b_in0.valid = 0; b_in0.data = '0; b_in0.first = 0; b_in0.last = 0;
    b_in1.valid = 0; b_in1.data = '0; b_in1.first = 0; b_in1.last = 0;
    b_lin.valid = 0; b_lin.data = '0; b_lin.first = 0; b_lin.last = 0;
    a_out0.ready = 1; a_out1.ready = 1; a_lout.ready = 1;
    b_out0.ready = 1; b_out1.ready = 1; b_lout.ready = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l0f [4];
    logic [1:0]  l0fl [4];
    logic [15:0] t2_exp [6];
    logic [15:0] lin_d [2];
    logic [15:0] t5_l0 [4];
    logic [15:0] t5_l1 [4];
    logic [15:0] t5_exp [8];
    logic [15:0] t4_d [6];
    logic [1:0]  t4_fl [6];
    int got, lidx, seen;

    // Lane0 rows: id 3 local packet (rows 0-4), then a 5-flit forward packet into a stalled ring_out0.
    vecs[0]  = '{1, 16'h0003, 1, 0, 1, 1, 0, 16'h0000, 0, 16'h0000};
    vecs[1]  = '{1, 16'hA001, 0, 0, 1, 1, 0, 16'h0000, 1, 16'h0003};
    vecs[2]  = '{1, 16'hA002, 0, 1, 1, 1, 0, 16'h0000, 1, 16'hA001};
    vecs[3]  = '{0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 1, 16'hA002};
    vecs[4]  = '{0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000};
    vecs[5]  = '{1, 16'h0005, 1, 0, 0, 1, 0, 16'h0000, 0, 16'h0000};
    vecs[6]  = '{1, 16'hB001, 0, 0, 0, 1, 1, 16'h0005, 0, 16'h0000};
    vecs[7]  = '{1, 16'hB002, 0, 0, 0, 1, 1, 16'h0005, 0, 16'h0000};
    vecs[8]  = '{1, 16'hB003, 0, 0, 0, 1, 1, 16'h0005, 0, 16'h0000};
    vecs[9]  = '{1, 16'hB004, 0, 1, 0, 0, 1, 16'h0005, 0, 16'h0000};
    vecs[10] = '{1, 16'hB004, 0, 1, 1, 0, 1, 16'h0005, 0, 16'h0000};
    vecs[11] = '{1, 16'hB004, 0, 1, 1, 1, 1, 16'hB001, 0, 16'h0000};
    vecs[12] = '{0, 16'h0000, 0, 0, 1, 1, 1, 16'hB002, 0, 16'h0000};
    vecs[13] = '{0, 16'h0000, 0, 0, 1, 1, 1, 16'hB003, 0, 16'h0000};
    vecs[14] = '{0, 16'h0000, 0, 0, 1, 1, 1, 16'hB004, 0, 16'h0000};
    vecs[15] = '{0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000};

    l0f    = '{16'h0005, 16'hC001, 16'h0009, 16'hC101};
    l0fl   = '{2'b10, 2'b01, 2'b10, 2'b01};
    lin_d  = '{16'hD000, 16'hD001};
    t2_exp = '{16'h0005, 16'hC001, 16'hD000, 16'hD001, 16'h0009, 16'hC101};
    t5_l0  = '{16'h1003, 16'h1101, 16'h1403, 16'h1501};
    t5_l1  = '{16'h2003, 16'h2101, 16'h2403, 16'h2501};
    t5_exp = '{16'h1003, 16'h1101, 16'h2003, 16'h2101, 16'h1403, 16'h1501, 16'h2403, 16'h2501};
    t4_d   = '{16'h0002, 16'hE001, 16'hE002, 16'h0002, 16'h0402, 16'hE101};
    t4_fl  = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01};

    rst_n = 1'b0;
    id0 = 10'd3;
    id1 = 10'd7;
    idle_inputs();
    do_reset("rst_init");

    // Tests 1 and 3 from the vector table.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_in0.valid  = vecs[i].v;
      a_in0.data   = vecs[i].d;
      a_in0.first  = vecs[i].f;
      a_in0.last   = vecs[i].l;
      a_out0.ready = vecs[i].ro0_rdy;
      #1;
      check($sformatf("vec%0d_in0_ready", i), a_in0.ready, vecs[i].exp_in_rdy);
      check($sformatf("vec%0d_ro0_valid", i), a_out0.valid, vecs[i].exp_ro0_v);
      if (vecs[i].exp_ro0_v) check($sformatf("vec%0d_ro0_data", i), a_out0.data, vecs[i].exp_ro0_d);
      check($sformatf("vec%0d_lo_valid", i), a_lout.valid, vecs[i].exp_lo_v);
      if (vecs[i].exp_lo_v) check($sformatf("vec%0d_lo_data", i), a_lout.data, vecs[i].exp_lo_d);
    end
    idle_inputs();

    // Test 2: lane0 and local_in contend for ring_out0; packets alternate and stay whole.
    do_reset("rst_t2");
    a_out0.ready = 0;
    a_lin.valid = 1; a_lin.data = lin_d[0]; a_lin.first = 1; a_lin.last = 0;
    for (int k = 0; k < 4; k++) begin
      a_in0.valid = 1; a_in0.data = l0f[k]; a_in0.first = l0fl[k][1]; a_in0.last = l0fl[k][0];
      @(negedge clk);
    end
    a_in0.valid = 0;
    #1;
    check("t2_stall_lin_ready", a_lin.ready, 0);
    check("t2_stall_in0_ready", a_in0.ready, 0);
    @(negedge clk);
    a_out0.ready = 1;
    got = 0;
    lidx = 0;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      if (lidx < 2) begin
        a_lin.valid = 1; a_lin.data = lin_d[lidx]; a_lin.first = (lidx == 0); a_lin.last = (lidx == 1);
      end else begin
        a_lin.valid = 0;
      end
      #1;
      if (a_out0.valid) begin
        check($sformatf("t2_ro0_flit%0d", got), a_out0.data, t2_exp[got]);
        got++;
      end
      if (a_lin.valid && a_lin.ready) lidx++;
      @(negedge clk);
    end
    a_lin.valid = 0;
    check("t2_flit_count", got, 6);
    #1;
    check("t2_ro0_quiet", a_out0.valid, 0);

    // Lane1 forwarding onto ring_out1 in the non-terminal node.
    @(negedge clk);
    a_in1.valid = 1; a_in1.data = 16'h3009; a_in1.first = 1; a_in1.last = 0;
    @(negedge clk);
    a_in1.data = 16'h3101; a_in1.first = 0; a_in1.last = 1;
    #1;
    check("fwd1_valid0", a_out1.valid, 1);
    check("fwd1_data0", a_out1.data, 16'h3009);
    @(negedge clk);
    a_in1.valid = 0;
    #1;
    check("fwd1_data1", a_out1.data, 16'h3101);
    check("fwd1_last1", a_out1.last, 1);
    @(negedge clk);
    #1;
    check("fwd1_quiet", a_out1.valid, 0);
    check("fwd1_lo_quiet", a_lout.valid, 0);

    // Test 5: both lanes deliver locally at once; whole packets alternate.
    @(negedge clk);
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      if (cyc < 4) begin
        a_in0.valid = 1; a_in0.data = t5_l0[cyc]; a_in0.first = (cyc % 2 == 0); a_in0.last = (cyc % 2 == 1);
        a_in1.valid = 1; a_in1.data = t5_l1[cyc]; a_in1.first = (cyc % 2 == 0); a_in1.last = (cyc % 2 == 1);
      end else begin
        a_in0.valid = 0;
        a_in1.valid = 0;
      end
      #1;
      if (cyc < 4) check($sformatf("t5_in1_ready%0d", cyc), a_in1.ready, 1);
      if (a_lout.valid) begin
        check($sformatf("t5_lo_flit%0d", got), a_lout.data, t5_exp[got]);
        got++;
      end
      @(negedge clk);
    end
    check("t5_flit_count", got, 8);
    check("t5_drop0_zero", drop0, 0);

    // Test 4: terminal node drops misaddressed lane1 packets and saturates its counter.
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 6) begin
        b_in1.valid = 1; b_in1.data = t4_d[cyc]; b_in1.first = t4_fl[cyc][1]; b_in1.last = t4_fl[cyc][0];
      end else begin
        b_in1.valid = 0;
      end
      #1;
      if (cyc < 6) check($sformatf("t4_in1_ready%0d", cyc), b_in1.ready, 1);
      if (b_out1.valid || b_lout.valid) seen++;
      @(negedge clk);
    end
    check("t4_ring_out1_silent", seen, 0);
    check("t4_drop_count", drop1, 3);
    force dut1.drop_count_q = 16'hFFFF;
    #1;
    release dut1.drop_count_q;
    @(negedge clk);
    b_in1.valid = 1; b_in1.data = 16'h0002; b_in1.first = 1; b_in1.last = 1;
    @(negedge clk);
    b_in1.valid = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t4_drop_saturated", drop1, 16'hFFFF);
    check("t4_in1_empty", b_in1.ready, 1);

    // Test 6: reset mid-packet clears outputs immediately; routing is clean afterwards.
    @(negedge clk);
    a_in0.valid = 1; a_in0.data = 16'h0003; a_in0.first = 1; a_in0.last = 0;
    @(negedge clk);
    a_in0.valid = 0;
    #1;
    check("t6_inflight_lo", a_lout.valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_lo_valid", a_lout.valid, 0);
    check("t6_rst_ro0_valid", a_out0.valid, 0);
    check("t6_rst_in0_ready", a_in0.ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_in0.valid = 1; a_in0.data = 16'h4005; a_in0.first = 1; a_in0.last = 1;
    @(negedge clk);
    a_in0.valid = 0;
    #1;
    check("t6_ro0_valid", a_out0.valid, 1);
    check("t6_ro0_data", a_out0.data, 16'h4005);
    check("t6_lo_quiet", a_lout.valid, 0);
    @(negedge clk);
    #1;
    check("t6_ro0_done", a_out0.valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
